pkt_buf_ctrl: RTL
=================

Name: pkt_buf_ctrl

Overview:
- Control stage for the 64-bit shared packet buffer in the CPU/FIFO datapath.
- Accepts one packet from the network input, hands the buffer to the CPU for in-place processing, then streams the packet out.
- Sits directly upstream of the 2:1 64-bit write-data mux. It drives that mux's select (0 = network word, 1 = CPU word) plus the external dual-port BRAM addresses and write enable.

Parameters:
- DATA_W, 64, buffer word width.
- ADDR_W, 8, buffer address width; capacity 2^ADDR_W words.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- in_data  in  DATA_W  network word; data path only, routed to mux data0 externally
- in_eop  in  1  marks last word of packet
- in_wr  in  1  network word valid
- in_rdy  out  1  controller can accept in_wr
- out_data  out  DATA_W  outgoing word, registered
- out_eop  out  1  last outgoing word
- out_wr  out  1  outgoing word valid
- out_rdy  in  1  downstream can take >=2 more words
- cpu_addr  in  ADDR_W  CPU buffer address
- cpu_we  in  1  CPU write strobe; data comes from cpu_wdata, routed to mux data1 externally
- cpu_done  in  1  CPU finished with packet
- cpu_rdata  out  DATA_W  CPU read data
- pkt_ready  out  1  buffer owned by CPU
- pkt_len  out  ADDR_W  index of last word of the held packet
- drop_cnt  out  16  count of dropped oversize packets, saturating
- mem_wsel  out  1  mux select
- mem_we  out  1  BRAM write enable
- mem_waddr  out  ADDR_W  BRAM write address
- mem_raddr  out  ADDR_W  BRAM read address
- mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; tail, rd_ptr and pkt_len = 0; out_wr, out_eop, out_data, pkt_ready and mem_we = 0; drop_cnt = 0.
- Reset takes effect mid-operation from any state; any held or in-flight packet is discarded.
- State machine has four states: IDLE, RECV, PROC, SEND.
- in_rdy=1 only in IDLE and RECV.
- In IDLE and RECV, mem_wsel=0, mem_we=in_wr, mem_waddr=tail.
- IDLE -> RECV on in_wr with !in_eop. IDLE -> PROC on in_wr with in_eop (single-word packet).
- Each accepted word: tail <= tail+1.
- RECV -> PROC on in_wr with in_eop; pkt_len <= tail (address of the eop word).
- Overflow: a word arriving at tail = 2^ADDR_W-1 without eop sets the drop flag.
  - While drop is set, mem_we=0 and words are consumed until eop.
  - On that eop: drop_cnt increments, tail <= 0, state -> IDLE.
- PROC: pkt_ready=1, mem_wsel=1, mem_we=cpu_we, mem_waddr=cpu_addr, mem_raddr=cpu_addr.
  - cpu_rdata = mem_rdata, valid one cycle after cpu_addr is presented.
  - cpu_done -> SEND with rd_ptr <= 0.
- cpu_we and cpu_done are ignored outside PROC.
- in_wr while in_rdy=0 is a protocol violation: ignored, no write.
- SEND: each cycle with out_rdy=1 and rd_ptr <= pkt_len, issue mem_raddr=rd_ptr and rd_ptr++.
  - One cycle later: out_wr=1, out_data=mem_rdata, out_eop=1 iff the issued address equals pkt_len.
  - If out_rdy drops, issue stops. The single in-flight word still emits; the out_rdy contract guarantees room.
  - After the eop word emits: state -> IDLE, tail <= 0, rd_ptr <= 0, pkt_ready=0.
- Latency: network eop accepted -> pkt_ready=1 on the next cycle. cpu_done -> first out_wr is 2 cycles.
- The 2^ADDR_W-word packet (eop exactly at the last address) is legal and not dropped.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'd0, RECV=2'd1, PROC=2'd2, SEND=2'd3
  - mux select constants: SEL_NET=0, SEL_CPU=1
  - default DATA_W and ADDR_W
- One natural sub-module, pkt_buf_rd_pipe: SEND-side issue/valid pipeline (rd_ptr, 1-cycle valid, eop compare).
- Existing parts are instantiated alongside at top level and stay outside this block: the 2:1 64-bit mux and the BRAM.

Test Plan:
1. 4-word packet A0..A3 (eop on A3) -> mem_we at addresses 0..3, mem_wsel=0; pkt_ready=1 next cycle; pkt_len=3.
2. In PROC, CPU writes 0xDEADBEEF_00000001 to addr 2 and reads addr 2 -> mem_wsel=1, mem_we at 2; cpu_rdata = written value one cycle after the read address.
3. cpu_done with out_rdy=1 -> out_wr on 4 consecutive cycles starting 2 cycles later: A0, A1, 0xDEADBEEF_00000001, A3, with out_eop only on the 4th; then in_rdy=1.
4. out_rdy deasserted after the first issue during SEND -> exactly one more out_wr; streaming resumes on reassert; no word duplicated or lost.
5. ADDR_W=3, 10-word packet -> drop_cnt=1, no write after address 7, return to IDLE, next 2-word packet lands at addresses 0..1.
6. reset_n=0 for one cycle mid-RECV (tail=5) -> next cycle: state IDLE, tail=0, all outputs at reset values, in_rdy=1 once reset_n=1.

Source files
------------

// File: rtl/pkt_buf_ctrl_pkg.sv
// Shared types and constants for the packet buffer control stage.
package pkt_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRecv = 2'd1,
        StProc = 2'd2,
        StSend = 2'd3
    } state_e;

    localparam logic SelNet = 1'b0;
    localparam logic SelCpu = 1'b1;

    localparam int unsigned DefDataW = 64;
    localparam int unsigned DefAddrW = 8;

endpackage

// File: rtl/pkt_buf_rd_pipe.sv
// SEND-side read issue pipeline: walks rd_ptr up to pkt_len and tracks the 1-cycle BRAM latency.
module pkt_buf_rd_pipe #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              active,
    input  logic              out_rdy,
    input  logic [ADDR_W-1:0] pkt_len,
    output logic [ADDR_W-1:0] raddr,
    output logic              valid,
    output logic              eop
);

    logic [ADDR_W-1:0] rd_ptr_q;
    logic              fin_q;
    logic              valid_q;
    logic              eop_q;
    logic              issue;
    logic              last;

    // fin_q rather than a wide compare so a full 2^ADDR_W packet does not re-issue after wrap.
    assign issue = active && out_rdy && !fin_q;
    assign last  = (rd_ptr_q == pkt_len);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            fin_q    <= 1'b0;
            valid_q  <= 1'b0;
            eop_q    <= 1'b0;
        end else begin
            valid_q <= issue;
            eop_q   <= issue && last;
            if (!active) begin
                rd_ptr_q <= '0;
                fin_q    <= 1'b0;
            end else if (issue) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                fin_q    <= last;
            end
        end
    end

    assign raddr = rd_ptr_q;
    assign valid = valid_q;
    assign eop   = eop_q;

endmodule

// File: rtl/pkt_buf_ctrl.sv
// Packet buffer controller: receive one packet, lend the buffer to the CPU, then stream it out.
module pkt_buf_ctrl
    import pkt_buf_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_eop,
    input  logic              in_wr,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eop,
    output logic              out_wr,
    input  logic              out_rdy,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              pkt_ready,
    output logic [ADDR_W-1:0] pkt_len,
    output logic [15:0]       drop_cnt,
    output logic              mem_wsel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q;
    logic [ADDR_W-1:0] tail_q;
    logic [ADDR_W-1:0] pkt_len_q;
    logic [15:0]       drop_cnt_q;
    logic              drop_q;
    logic              pkt_ready_q;
    logic              accepting;
    logic [ADDR_W-1:0] rd_addr;

    // in_data is unused here: it reaches the BRAM through the external write-data mux.
    logic unused_in_data;
    assign unused_in_data = ^in_data;

    assign accepting = reset_n && (state_q == StIdle || state_q == StRecv);
    assign in_rdy    = accepting;

    always_comb begin
        mem_wsel  = SelNet;
        mem_we    = 1'b0;
        mem_waddr = tail_q;
        mem_raddr = rd_addr;
        if (accepting) begin
            mem_we = in_wr && !drop_q;
        end else if (state_q == StProc) begin
            mem_wsel  = SelCpu;
            mem_we    = reset_n && cpu_we;
            mem_waddr = cpu_addr;
            mem_raddr = cpu_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            tail_q      <= '0;
            pkt_len_q   <= '0;
            drop_cnt_q  <= '0;
            drop_q      <= 1'b0;
            pkt_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StRecv: begin
                    if (in_wr) begin
                        if (drop_q) begin
                            if (in_eop) begin
                                drop_q  <= 1'b0;
                                tail_q  <= '0;
                                state_q <= StIdle;
                                if (drop_cnt_q != 16'hffff) drop_cnt_q <= drop_cnt_q + 16'd1;
                            end
                        end else begin
                            tail_q <= tail_q + ADDR_W'(1);
                            if (in_eop) begin
                                pkt_len_q   <= tail_q;
                                pkt_ready_q <= 1'b1;
                                state_q     <= StProc;
                            end else begin
                                state_q <= StRecv;
                                if (tail_q == '1) drop_q <= 1'b1;
                            end
                        end
                    end
                end
                StProc: begin
                    if (cpu_done) state_q <= StSend;
                end
                StSend: begin
                    if (out_wr && out_eop) begin
                        state_q     <= StIdle;
                        tail_q      <= '0;
                        pkt_ready_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    pkt_buf_rd_pipe #(
        .ADDR_W (ADDR_W)
    ) u_rd_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (state_q == StSend),
        .out_rdy (out_rdy),
        .pkt_len (pkt_len_q),
        .raddr   (rd_addr),
        .valid   (out_wr),
        .eop     (out_eop)
    );

    // BRAM output is already registered; gate it so idle cycles show zero.
    assign out_data  = out_wr ? mem_rdata : '0;
    assign cpu_rdata = mem_rdata;
    assign pkt_ready = pkt_ready_q;
    assign pkt_len   = pkt_len_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
